sdram_avs_bridge: RTL and testbench

SDRAM_AVS_BRIDGE -- requirements
Module: sdram_avs_bridge

---
 rtl/sdram_avs_bridge_pkg.sv | 29 ++
 rtl/sdram_avs_bridge_if.sv | 44 ++++
 rtl/sdram_sync_fifo.sv | 59 +++++
 rtl/sdram_avs_bridge.sv | 95 +++++++++
 tb/tb_sdram_avs_bridge.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_avs_bridge_pkg.sv
// Shared SDRAM bridge types: Avalon-MM widths and the request-FIFO entry layout.
package sdram_avs_bridge_pkg;

  localparam int unsigned AVS_AW   = 24;
  localparam int unsigned AVS_DW   = 32;
  localparam int unsigned AVS_BYTE = AVS_DW / 8;

  typedef struct packed {
    logic                write;
    logic [AVS_AW-1:0]   address;
    logic [AVS_DW-1:0]   writedata;
    logic [AVS_BYTE-1:0] byteenable;
  } req_entry_t;

  localparam int unsigned REQ_W = $bits(req_entry_t);

  function automatic req_entry_t make_req(input logic                write,
                                          input logic [AVS_AW-1:0]   address,
                                          input logic [AVS_DW-1:0]   writedata,
                                          input logic [AVS_BYTE-1:0] byteenable);
    req_entry_t e;
    e.write      = write;
    e.address    = address;
    e.writedata  = writedata;
    e.byteenable = byteenable;
    return e;
  endfunction

endpackage

// File: rtl/sdram_avs_bridge_if.sv
// Avalon-MM slave side plus access-controller request/response channels of the bridge.
interface sdram_avs_bridge_if;
  import sdram_avs_bridge_pkg::*;

  logic                avs_read;
  logic                avs_write;
  logic [AVS_AW-1:0]   avs_address;
  logic [AVS_DW-1:0]   avs_writedata;
  logic [AVS_BYTE-1:0] avs_byteenable;
  logic                avs_waitrequest;
  logic [AVS_DW-1:0]   avs_readdata;
  logic                avs_readdatavalid;

  logic                bus_req_valid;
  logic                bus_req_write;
  logic [AVS_AW-1:0]   bus_req_address;
  logic [AVS_DW-1:0]   bus_req_writedata;
  logic [AVS_BYTE-1:0] bus_req_byteenable;
  logic                bus_req_ready;

  logic                bus_resp_valid;
  logic [AVS_DW-1:0]   bus_resp_readdata;

  // Bridge view.
  modport slave (
    input  avs_read, avs_write, avs_address, avs_writedata, avs_byteenable,
    output avs_waitrequest, avs_readdata, avs_readdatavalid,
    output bus_req_valid, bus_req_write, bus_req_address, bus_req_writedata,
    output bus_req_byteenable,
    input  bus_req_ready,
    input  bus_resp_valid, bus_resp_readdata
  );

  // Environment view: Avalon master plus access controller.
  modport master (
    output avs_read, avs_write, avs_address, avs_writedata, avs_byteenable,
    input  avs_waitrequest, avs_readdata, avs_readdatavalid,
    input  bus_req_valid, bus_req_write, bus_req_address, bus_req_writedata,
    input  bus_req_byteenable,
    output bus_req_ready,
    output bus_resp_valid, bus_resp_readdata
  );

endinterface

// File: rtl/sdram_sync_fifo.sv
// Single-clock show-ahead FIFO; rdata always presents the head entry. DEPTH must be a power of two.
module sdram_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  // Full blocks push even when a pop happens in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/sdram_avs_bridge.sv
// Avalon-MM slave to SDRAM access-controller bridge with in-order request FIFO and read tracking.
// Define SDRAM_AVS_RESP_REG_EN to register avs_readdata/avs_readdatavalid (one cycle of latency).
module sdram_avs_bridge
  import sdram_avs_bridge_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_RD     = 4
) (
  input logic               clk,
  input logic               reset,
  input logic               init_done,
  sdram_avs_bridge_if.slave br
);

  localparam int unsigned CNT_W = $clog2(MAX_RD + 1);
  localparam logic [CNT_W-1:0] RD_LIMIT = CNT_W'(MAX_RD);

  logic             fifo_full;
  logic             fifo_empty;
  logic             waitrequest;
  logic             accept;
  logic             rd_accept;
  logic             resp_take;
  logic             pop;
  logic [CNT_W-1:0] rd_cnt_q;
  req_entry_t       push_entry;
  req_entry_t       head_entry;

  // Reset term keeps the master stalled while state is being cleared.
  assign waitrequest = reset | ~init_done | fifo_full |
                       (br.avs_read & ~br.avs_write & (rd_cnt_q == RD_LIMIT));
  assign accept      = (br.avs_read | br.avs_write) & ~waitrequest;
  assign rd_accept   = accept & br.avs_read & ~br.avs_write;
  // Responses with nothing outstanding are stray and get dropped.
  assign resp_take   = br.bus_resp_valid & (rd_cnt_q != '0);
  assign pop         = ~fifo_empty & br.bus_req_ready;

  assign push_entry  = make_req(br.avs_write, br.avs_address, br.avs_writedata,
                                br.avs_byteenable);

  sdram_sync_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign br.avs_waitrequest    = waitrequest;
  assign br.bus_req_valid      = ~fifo_empty;
  assign br.bus_req_write      = head_entry.write;
  assign br.bus_req_address    = head_entry.address;
  assign br.bus_req_writedata  = head_entry.writedata;
  assign br.bus_req_byteenable = head_entry.byteenable;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q <= '0;
    end else if (rd_accept & ~resp_take) begin
      rd_cnt_q <= rd_cnt_q + 1'b1;
    end else if (~rd_accept & resp_take) begin
      rd_cnt_q <= rd_cnt_q - 1'b1;
    end
  end

`ifdef SDRAM_AVS_RESP_REG_EN
  logic [AVS_DW-1:0] readdata_q;
  logic              readdatavalid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      readdatavalid_q <= 1'b0;
      readdata_q      <= '0;
    end else begin
      readdatavalid_q <= resp_take;
      if (resp_take) begin
        readdata_q <= br.bus_resp_readdata;
      end
    end
  end

  assign br.avs_readdata      = readdata_q;
  assign br.avs_readdatavalid = readdatavalid_q;
`else
  assign br.avs_readdata      = br.bus_resp_readdata;
  assign br.avs_readdatavalid = resp_take;
`endif

endmodule

// File: tb/tb_sdram_avs_bridge.sv
// Scoreboard bench for sdram_avs_bridge: queued expected requests/read data checked as the DUT emits them.
module tb_sdram_avs_bridge;
  import sdram_avs_bridge_pkg::*;

  localparam int unsigned FifoDepth = 4;
  localparam int unsigned MaxRd     = 4;

  logic clk = 1'b0;
  logic reset;
  logic init_done;

  sdram_avs_bridge_if bif ();

  sdram_avs_bridge #(
    .FIFO_DEPTH (FifoDepth),
    .MAX_RD     (MaxRd)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .init_done (init_done),
    .br        (bif)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic                wr;
    logic [AVS_AW-1:0]   addr;
    logic [AVS_DW-1:0]   data;
    logic [AVS_BYTE-1:0] be;
  } exp_req_t;

  exp_req_t          exp_req_q [$];
  logic [AVS_DW-1:0] exp_rd_q  [$];

  function automatic exp_req_t mk(input logic wr, input logic [AVS_AW-1:0] a,
                                  input logic [AVS_DW-1:0] d, input logic [AVS_BYTE-1:0] be);
    exp_req_t e;
    e.wr = wr; e.addr = a; e.data = d; e.be = be;
    return e;
  endfunction

  // Scoreboard: every issued request and every read response is checked against the queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (bif.bus_req_valid && bif.bus_req_ready) begin
        exp_req_t got;
        exp_req_t want;
        got = mk(bif.bus_req_write, bif.bus_req_address, bif.bus_req_writedata,
                 bif.bus_req_byteenable);
        n_cmp++;
        if (exp_req_q.size() == 0) begin
          n_fail++;
          $display("FAIL bus_req_unexpected: got %h, required no request", got);
        end else begin
          want = exp_req_q.pop_front();
          if (got !== want) begin
            n_fail++;
            $display("FAIL bus_req_fields: got %h, required %h", got, want);
          end
        end
      end
      if (bif.avs_readdatavalid) begin
        n_cmp++;
        if (exp_rd_q.size() == 0) begin
          n_fail++;
          $display("FAIL readdatavalid_unexpected: got data %h, required no response",
                   bif.avs_readdata);
        end else begin
          logic [AVS_DW-1:0] want_d;
          want_d = exp_rd_q.pop_front();
          if (bif.avs_readdata !== want_d) begin
            n_fail++;
            $display("FAIL readdata: got %h, required %h", bif.avs_readdata, want_d);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic rd, input logic wr, input logic [AVS_AW-1:0] a,
                           input logic [AVS_DW-1:0] d, input logic [AVS_BYTE-1:0] be);
    bif.avs_read       = rd;
    bif.avs_write      = wr;
    bif.avs_address    = a;
    bif.avs_writedata  = d;
    bif.avs_byteenable = be;
  endtask

  task automatic idle();
    drive_req(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    init_done = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (bif.avs_waitrequest !== 1'b1) begin
      n_fail++; $display("FAIL reset_waitreq: got %b, required 1", bif.avs_waitrequest);
    end
    n_cmp++;
    if (bif.bus_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_req_valid: got %b, required 0", bif.bus_req_valid);
    end
    n_cmp++;
    if (bif.avs_readdatavalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rdv: got %b, required 0", bif.avs_readdatavalid);
    end
    init_done = 1'b1;
    drive_req(1'b0, 1'b1, 24'h0000AA, 32'h12345678, 4'hF);
    #1;
    n_cmp++;
    if (bif.avs_waitrequest !== 1'b1) begin
      n_fail++; $display("FAIL reset_waitreq_init: got %b, required 1", bif.avs_waitrequest);
    end
    tick();
    idle();
    init_done = 1'b0;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (bif.bus_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_push: got %b, required 0", bif.bus_req_valid);
    end
  endtask

  task automatic test_init_gate();
    init_done = 1'b0;
    drive_req(1'b0, 1'b1, 24'h000100, 32'hCAFE0001, 4'hF);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (bif.avs_waitrequest !== 1'b1) begin
        n_fail++; $display("FAIL init_waitreq: got %b, required 1", bif.avs_waitrequest);
      end
      n_cmp++;
      if (bif.bus_req_valid !== 1'b0) begin
        n_fail++; $display("FAIL init_req_valid: got %b, required 0", bif.bus_req_valid);
      end
      tick();
    end
    init_done = 1'b1;
    #1;
    n_cmp++;
    if (bif.avs_waitrequest !== 1'b0) begin
      n_fail++; $display("FAIL init_accept: got %b, required 0", bif.avs_waitrequest);
    end
    exp_req_q.push_back(mk(1'b1, 24'h000100, 32'hCAFE0001, 4'hF));
    tick();
    idle();
    #1;
    n_cmp++;
    if (bif.bus_req_valid !== 1'b1) begin
      n_fail++; $display("FAIL init_latency: got %b, required 1", bif.bus_req_valid);
    end
    bif.bus_req_ready = 1'b1;
    tick();
    bif.bus_req_ready = 1'b0;
    #1;
    n_cmp++;
    if (bif.bus_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL init_drained: got %b, required 0", bif.bus_req_valid);
    end
  endtask

  task automatic test_fifo_full();
    bif.bus_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_req(1'b0, 1'b1, AVS_AW'(32'h200 + i), 32'hD0000000 + i, 4'hF);
      #1;
      n_cmp++;
      if (i < FifoDepth) begin
        if (bif.avs_waitrequest !== 1'b0) begin
          n_fail++; $display("FAIL full_accept_%0d: got %b, required 0", i, bif.avs_waitrequest);
        end
        exp_req_q.push_back(mk(1'b1, AVS_AW'(32'h200 + i), 32'hD0000000 + i, 4'hF));
        tick();
      end else if (bif.avs_waitrequest !== 1'b1) begin
        n_fail++; $display("FAIL full_stall: got %b, required 1", bif.avs_waitrequest);
      end
    end
    bif.bus_req_ready = 1'b1;
    #1;
    n_cmp++;
    if (bif.avs_waitrequest !== 1'b1) begin
      n_fail++; $display("FAIL full_pop_same_cycle: got %b, required 1", bif.avs_waitrequest);
    end
    tick();
    bif.bus_req_ready = 1'b0;
    #1;
    n_cmp++;
    if (bif.avs_waitrequest !== 1'b0) begin
      n_fail++; $display("FAIL full_after_pop: got %b, required 0", bif.avs_waitrequest);
    end
    exp_req_q.push_back(mk(1'b1, 24'h000204, 32'hD0000004, 4'hF));
    tick();
    idle();
    bif.bus_req_ready = 1'b1;
    repeat (4) tick();
    bif.bus_req_ready = 1'b0;
    #1;
    n_cmp++;
    if (bif.bus_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL full_drained: got %b, required 0", bif.bus_req_valid);
    end
  endtask

  // Fills the read tracker to MaxRd and expects the next read to stall.
  task automatic test_fill_reads(input logic [AVS_AW-1:0] base);
    bif.bus_req_ready = 1'b1;
    for (int i = 0; i <= MaxRd; i++) begin
      drive_req(1'b1, 1'b0, base + AVS_AW'(i), '0, 4'hF);
      #1;
      n_cmp++;
      if (i < MaxRd) begin
        if (bif.avs_waitrequest !== 1'b0) begin
          n_fail++; $display("FAIL rd_accept_%0d: got %b, required 0", i, bif.avs_waitrequest);
        end
        exp_req_q.push_back(mk(1'b0, base + AVS_AW'(i), '0, 4'hF));
        tick();
      end else if (bif.avs_waitrequest !== 1'b1) begin
        n_fail++; $display("FAIL rd_limit_stall: got %b, required 1", bif.avs_waitrequest);
      end
    end
  endtask

  task automatic test_max_rd();
    test_fill_reads(24'h000300);
    bif.bus_resp_valid    = 1'b1;
    bif.bus_resp_readdata = 32'h0000A5A5;
    exp_rd_q.push_back(32'h0000A5A5);
    #1;
    n_cmp++;
    if (bif.avs_waitrequest !== 1'b1) begin
      n_fail++; $display("FAIL rd_resp_cycle_stall: got %b, required 1", bif.avs_waitrequest);
    end
`ifndef SDRAM_AVS_RESP_REG_EN
    n_cmp++;
    if (bif.avs_readdatavalid !== 1'b1) begin
      n_fail++; $display("FAIL rd_resp_latency: got %b, required 1", bif.avs_readdatavalid);
    end
`endif
    tick();
    bif.bus_resp_valid = 1'b0;
    #1;
`ifdef SDRAM_AVS_RESP_REG_EN
    n_cmp++;
    if (bif.avs_readdatavalid !== 1'b1) begin
      n_fail++; $display("FAIL rd_resp_latency: got %b, required 1", bif.avs_readdatavalid);
    end
`endif
    n_cmp++;
    if (bif.avs_waitrequest !== 1'b0) begin
      n_fail++; $display("FAIL rd_fifth_accept: got %b, required 0", bif.avs_waitrequest);
    end
    exp_req_q.push_back(mk(1'b0, 24'h000304, '0, 4'hF));
    tick();
    idle();
    for (int k = 0; k < 4; k++) begin
      bif.bus_resp_valid    = 1'b1;
      bif.bus_resp_readdata = 32'h00001000 + k;
      exp_rd_q.push_back(32'h00001000 + k);
      tick();
    end
    bif.bus_resp_valid = 1'b0;
    tick();
  endtask

  task automatic test_order();
    logic [AVS_AW-1:0]   addr_t [4] = '{24'h000010, 24'h000020, 24'h000030, 24'h000040};
    logic [AVS_DW-1:0]   data_t [4] = '{32'h11112222, 32'h0, 32'h33334444, 32'h55556666};
    logic [AVS_BYTE-1:0] be_t   [4] = '{4'hF, 4'h3, 4'h5, 4'hC};
    logic                rd_t   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic                wr_t   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bif.bus_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_req(rd_t[i], wr_t[i], addr_t[i], data_t[i], be_t[i]);
      #1;
      n_cmp++;
      if (bif.avs_waitrequest !== 1'b0) begin
        n_fail++; $display("FAIL order_accept_%0d: got %b, required 0", i, bif.avs_waitrequest);
      end
      exp_req_q.push_back(mk(wr_t[i], addr_t[i], data_t[i], be_t[i]));
      tick();
    end
    idle();
    bif.bus_req_ready = 1'b1;
    repeat (4) tick();
    bif.bus_req_ready = 1'b0;
    // Only the plain read is outstanding; the read+write was taken as a write.
    bif.bus_resp_valid    = 1'b1;
    bif.bus_resp_readdata = 32'h0000BEEF;
    exp_rd_q.push_back(32'h0000BEEF);
    tick();
    bif.bus_resp_readdata = 32'h0000DEAD;
    #1;
`ifndef SDRAM_AVS_RESP_REG_EN
    n_cmp++;
    if (bif.avs_readdatavalid !== 1'b0) begin
      n_fail++; $display("FAIL order_rw_no_rdcnt: got %b, required 0", bif.avs_readdatavalid);
    end
`endif
    tick();
    bif.bus_resp_valid = 1'b0;
    #1;
`ifdef SDRAM_AVS_RESP_REG_EN
    n_cmp++;
    if (bif.avs_readdatavalid !== 1'b0) begin
      n_fail++; $display("FAIL order_rw_no_rdcnt: got %b, required 0", bif.avs_readdatavalid);
    end
`endif
    tick();
  endtask

  task automatic test_cnt_same_cycle();
    bif.bus_req_ready = 1'b1;
    drive_req(1'b1, 1'b0, 24'h000050, '0, 4'hF);
    exp_req_q.push_back(mk(1'b0, 24'h000050, '0, 4'hF));
    tick();
    drive_req(1'b1, 1'b0, 24'h000054, '0, 4'hF);
    bif.bus_resp_valid    = 1'b1;
    bif.bus_resp_readdata = 32'h00000077;
    exp_rd_q.push_back(32'h00000077);
    #1;
    n_cmp++;
    if (bif.avs_waitrequest !== 1'b0) begin
      n_fail++; $display("FAIL same_cycle_accept: got %b, required 0", bif.avs_waitrequest);
    end
    exp_req_q.push_back(mk(1'b0, 24'h000054, '0, 4'hF));
    tick();
    idle();
    bif.bus_resp_readdata = 32'h00000088;
    exp_rd_q.push_back(32'h00000088);
    tick();
    bif.bus_resp_readdata = 32'h00000099;
    #1;
`ifndef SDRAM_AVS_RESP_REG_EN
    n_cmp++;
    if (bif.avs_readdatavalid !== 1'b0) begin
      n_fail++; $display("FAIL stray_dropped: got %b, required 0", bif.avs_readdatavalid);
    end
`endif
    tick();
    bif.bus_resp_valid = 1'b0;
    #1;
`ifdef SDRAM_AVS_RESP_REG_EN
    n_cmp++;
    if (bif.avs_readdatavalid !== 1'b0) begin
      n_fail++; $display("FAIL stray_dropped: got %b, required 0", bif.avs_readdatavalid);
    end
`endif
    tick();
  endtask

  task automatic test_reset_mid();
    bif.bus_req_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_req(1'b1, 1'b0, AVS_AW'(32'h60 + 4 * i), '0, 4'hF);
      exp_req_q.push_back(mk(1'b0, AVS_AW'(32'h60 + 4 * i), '0, 4'hF));
      tick();
    end
    idle();
    tick();
    bif.bus_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b0, 1'b1, AVS_AW'(32'h70 + i), 32'h70700000 + i, 4'hF);
      tick();
    end
    idle();
    reset = 1'b1;
    exp_req_q.delete();
    exp_rd_q.delete();
    #1;
    n_cmp++;
    if (bif.avs_waitrequest !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_waitreq: got %b, required 1", bif.avs_waitrequest);
    end
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (bif.bus_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_fifo_empty: got %b, required 0", bif.bus_req_valid);
    end
    bif.bus_resp_valid    = 1'b1;
    bif.bus_resp_readdata = 32'h0000FACE;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (bif.avs_readdatavalid !== 1'b0) begin
        n_fail++; $display("FAIL mid_reset_no_resp: got %b, required 0", bif.avs_readdatavalid);
      end
    end
    bif.bus_resp_valid = 1'b0;
    tick();
    // A full MaxRd reads must again be accepted, proving the tracker restarted at zero.
    test_fill_reads(24'h000080);
    idle();
    for (int k = 0; k < 4; k++) begin
      bif.bus_resp_valid    = 1'b1;
      bif.bus_resp_readdata = 32'h00002000 + k;
      exp_rd_q.push_back(32'h00002000 + k);
      tick();
    end
    bif.bus_resp_valid = 1'b0;
    bif.bus_req_ready  = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    reset                 = 1'b1;
    init_done             = 1'b0;
    idle();
    bif.bus_req_ready     = 1'b0;
    bif.bus_resp_valid    = 1'b0;
    bif.bus_resp_readdata = '0;
    test_reset();
    test_init_gate();
    test_fifo_full();
    test_max_rd();
    test_order();
    test_cnt_same_cycle();
    test_reset_mid();
    n_cmp++;
    if (exp_req_q.size() != 0 || exp_rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d req / %0d rd pending, required 0 / 0",
               exp_req_q.size(), exp_rd_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
